// File: rtl/multicycle_adder_ctrl_pkg.sv
// Shared adders package for the multicycle adder controller.
// Holds the FSM state encoding and the default slice geometry so the
// controller and any neighbouring adder blocks agree on them.
//
// Contents:
//   DEF_N          default slice width in bits
//   DEF_K          default number of slices
//   adder_state_e  controller FSM states (IDLE/BUSY/DONE)
//   twos_ovf       two's-complement overflow from operand/sum sign bits
package multicycle_adder_ctrl_pkg;

    localparam int DEF_N = 4;
    localparam int DEF_K = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } adder_state_e;

    // Overflow occurs when both operands share a sign and the sum's sign differs.
    function automatic logic twos_ovf(input logic a_msb, input logic b_msb,
                                      input logic sum_msb);
        return (a_msb == b_msb) && (sum_msb != a_msb);
    endfunction

endpackage

// File: rtl/multicycle_adder_ctrl_carry_select.sv
// carry_select_adder_block: combinational N-bit carry-select slice.
// Both carry-in cases are precomputed and the real carry-in picks one.
//
// Ports:
//   a, b  [N-1:0]  slice operands
//   cin            slice carry-in
//   sum   [N-1:0]  slice sum
//   cout           slice carry-out
module carry_select_adder_block
    import multicycle_adder_ctrl_pkg::*;
#(
    parameter int N = DEF_N
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    logic [N:0] sum_c0;
    logic [N:0] sum_c1;

    // Precompute the carry-in=0 and carry-in=1 results, then select.
    always_comb begin
        sum_c0 = {1'b0, a} + {1'b0, b};
        sum_c1 = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, 1'b1};
        {cout, sum} = cin ? sum_c1 : sum_c0;
    end

endmodule

// File: rtl/multicycle_adder_ctrl.sv
// multicycle_adder_ctrl: W = N*K bit adder that reuses one N-bit
// carry-select slice over K BUSY cycles, rippling the carry through a
// register. Result is held in DONE until the consumer accepts it.
//
// Optional feature macro: ADDER_OVF_EN adds the out_ovf port.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   operand handshake (ready only in IDLE)
//   in_a, in_b [W-1:0]  operands; in_cin carry-in
//   out_valid/out_ready result handshake (valid only in DONE)
//   out_sum [W-1:0]     registered sum; out_cout registered carry-out
//   out_ovf             two's-complement overflow (ADDER_OVF_EN only)
//   busy                high in BUSY or DONE
module multicycle_adder_ctrl
    import multicycle_adder_ctrl_pkg::*;
#(
    parameter int N = DEF_N,
    parameter int K = DEF_K
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N*K-1:0] in_a,
    input  logic [N*K-1:0] in_b,
    input  logic           in_cin,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N*K-1:0] out_sum,
    output logic           out_cout,
`ifdef ADDER_OVF_EN
    output logic           out_ovf,
`endif
    output logic           busy
);

    localparam int W  = N * K;
    localparam int IW = (K > 1) ? $clog2(K) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(K - 1);

    adder_state_e  state;
    adder_state_e  state_next;
    logic [W-1:0]  a_reg;
    logic [W-1:0]  b_reg;
    logic [W-1:0]  sum_reg;
    logic          carry_reg;
    logic          cout_reg;
    logic [IW-1:0] idx;
    logic [N-1:0]  a_slice;
    logic [N-1:0]  b_slice;
    logic [N-1:0]  slice_sum;
    logic          slice_cout;
    logic          last_slice;
`ifdef ADDER_OVF_EN
    logic          ovf_reg;
`endif

    // Pick the operand slice addressed by the current index.
    always_comb begin
        a_slice    = a_reg[idx*N +: N];
        b_slice    = b_reg[idx*N +: N];
        last_slice = (idx == LAST_IDX);
    end

    carry_select_adder_block #(
        .N (N)
    ) u_slice (
        .a    (a_slice),
        .b    (b_slice),
        .cin  (carry_reg),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                busy = 1'b1;
                if (last_slice) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: operands latch on accept; only BUSY touches the sum, one
    // slice per cycle, so untouched slices keep their previous contents.
    // The final carry (and overflow) are captured on the last slice so
    // they stay stable through DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            cout_reg  <= 1'b0;
            idx       <= '0;
`ifdef ADDER_OVF_EN
            ovf_reg   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg     <= in_a;
                        b_reg     <= in_b;
                        carry_reg <= in_cin;
                        idx       <= '0;
                    end
                end
                BUSY: begin
                    sum_reg[idx*N +: N] <= slice_sum;
                    carry_reg           <= slice_cout;
                    if (last_slice) begin
                        cout_reg <= slice_cout;
`ifdef ADDER_OVF_EN
                        ovf_reg  <= twos_ovf(a_reg[W-1], b_reg[W-1], slice_sum[N-1]);
`endif
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign out_sum  = sum_reg;
    assign out_cout = cout_reg;
`ifdef ADDER_OVF_EN
    assign out_ovf  = ovf_reg;
`endif

endmodule

// File: tb/tb_multicycle_adder_ctrl.sv
// Testbench for multicycle_adder_ctrl (default N=4, K=8, W=32).
// Stimulus pushes the expected result of each accepted add into a
// scoreboard; an independent monitor compares every cycle the DUT shows
// out_valid and pops on the handshake. Define ADDER_OVF_EN to also check out_ovf.
module tb_multicycle_adder_ctrl;

    localparam int N = 4;
    localparam int K = 8;
    localparam int W = N * K;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         busy;
`ifdef ADDER_OVF_EN
    logic         out_ovf;
`endif

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int           acceptEdge;
    } exp_t;

    exp_t scoreboard[$];
    exp_t monItem;
    int   checksTotal = 0;
    int   checksPassed = 0;
    int   cycleNum = 0;
    int   readyMode = 1;
    bit   latencyChecked = 1'b0;

    multicycle_adder_ctrl #(
        .N (N),
        .K (K)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
`ifdef ADDER_OVF_EN
        .out_ovf   (out_ovf),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleNum++;

    // out_ready changes shortly after each rising edge so the monitor at the
    // falling edge sees the value the next rising edge will use.
    always @(posedge clk) begin
        #2;
        case (readyMode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checksTotal++;
        if (actual === expected) begin
            checksPassed++;
        end else begin
            $display("[TB] FAIL %s actual=%0h expected=%0h at t=%0t", name, actual, expected, $time);
        end
    endtask

    // Reference: plain unsigned addition over W+1 bits.
    function automatic exp_t modelResult(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin);
        exp_t       e;
        logic [W:0] full;
        full   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        e.sum  = full[W-1:0];
        e.cout = full[W];
        e.ovf  = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
        e.acceptEdge = 0;
        return e;
    endfunction

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin);
        exp_t e;
        int   waited = 0;
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            checkOutput("ready_timeout", 64'(in_ready), 64'd1);
            return;
        end
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        in_valid = 1'b1;
        @(negedge clk);
        e = modelResult(a, b, cin);
        e.acceptEdge = cycleNum;
        scoreboard.push_back(e);
        in_valid = 1'b0;
    endtask

    task automatic waitDrain();
        int waited = 0;
        while ((scoreboard.size() != 0 || !in_ready) && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        if (scoreboard.size() != 0 || !in_ready) begin
            checkOutput("drain_timeout", 64'(scoreboard.size()), 64'd0);
        end
    endtask

    // Monitor: latency counts the accept edge as cycle 1, so DONE entered
    // K edges later reads as K+1.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (scoreboard.size() == 0) begin
                checkOutput("unexpected_output", 64'(scoreboard.size()), 64'd1);
            end else begin
                monItem = scoreboard[0];
                if (!latencyChecked) begin
                    checkOutput("latency", 64'(cycleNum - monItem.acceptEdge + 1), 64'(K + 1));
                    latencyChecked = 1'b1;
                end
                checkOutput("out_sum", 64'(out_sum), 64'(monItem.sum));
                checkOutput("out_cout", 64'(out_cout), 64'(monItem.cout));
`ifdef ADDER_OVF_EN
                checkOutput("out_ovf", 64'(out_ovf), 64'(monItem.ovf));
`endif
                checkOutput("done_in_ready", 64'(in_ready), 64'd0);
                checkOutput("done_busy", 64'(busy), 64'd1);
                if (out_ready) begin
                    void'(scoreboard.pop_front());
                    latencyChecked = 1'b0;
                end
            end
        end
    end

    initial begin
        int waited;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_out_sum", 64'(out_sum), 64'd0);
        checkOutput("rst_out_cout", 64'(out_cout), 64'd0);
`ifdef ADDER_OVF_EN
        checkOutput("rst_out_ovf", 64'(out_ovf), 64'd0);
`endif
        rst = 1'b0;
        @(negedge clk);

        // Full carry ripple and a lone carry-in.
        applyStimulus(32'hFFFF_FFFF, 32'h1, 1'b0);
        applyStimulus(32'h0, 32'h0, 1'b1);
        waitDrain();

        // Backpressure: hold the result for 5 DONE cycles, then release.
        readyMode = 0;
        applyStimulus(32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
        waited = 0;
        while (!out_valid && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("bp_reach_done", 64'(out_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_in_ready", 64'(in_ready), 64'd0);
            checkOutput("bp_out_valid", 64'(out_valid), 64'd1);
            @(negedge clk);
        end
        readyMode = 1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("bp_release_in_ready", 64'(in_ready), 64'd1);
        checkOutput("bp_release_out_valid", 64'(out_valid), 64'd0);

        // A request during BUSY must be ignored.
        applyStimulus(32'hCAFE_0001, 32'h0000_1111, 1'b0);
        in_a     = 32'h5;
        in_b     = 32'h77;
        in_cin   = 1'b1;
        in_valid = 1'b1;
        checkOutput("ignored_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        in_valid = 1'b0;
        waitDrain();
        repeat (K + 3) @(negedge clk);
        checkOutput("ignored_idle", 64'(in_ready), 64'd1);

        // Reset during the 4th BUSY cycle aborts the add.
        applyStimulus(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        scoreboard.delete();
        latencyChecked = 1'b0;
        #1;
        checkOutput("abort_in_ready", 64'(in_ready), 64'd1);
        checkOutput("abort_busy", 64'(busy), 64'd0);
        #2;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("abort_out_valid", 64'(out_valid), 64'd0);
        checkOutput("abort_out_sum", 64'(out_sum), 64'd0);
        checkOutput("abort_out_cout", 64'(out_cout), 64'd0);
        applyStimulus(32'h3, 32'h4, 1'b0);
        waitDrain();

        // Signed overflow corners.
        applyStimulus(32'h7FFF_FFFF, 32'h1, 1'b0);
        applyStimulus(32'h8000_0000, 32'h8000_0000, 1'b0);
        waitDrain();

        // Random operands with random consumer backpressure.
        readyMode = 2;
        for (int i = 0; i < 40; i++) begin
            applyStimulus(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
        end
        readyMode = 1;
        waitDrain();

        $display("[TB] %0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule

// File: doc/multicycle_adder_ctrl.md
MULTICYCLE_ADDER_CTRL -- requirements
Module: multicycle_adder_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with port names clk and rst.
REQ-002 Parameter N SHALL default to 4 and set the slice width in bits.
REQ-003 Parameter K SHALL default to 8 and set the number of slices; operand width W = N*K.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 in_valid  input  1  operand request valid.
REQ-007 in_ready  output  1  block can accept operands.
REQ-008 in_a, in_b  input  W  operands.
REQ-009 in_cin  input  1  carry-in.
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 out_sum  output  W  registered sum.
REQ-013 out_cout  output  1  registered final carry-out.
REQ-014 busy  output  1  high in BUSY or DONE.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, BUSY and DONE.
REQ-016 IDLE: in_ready=1; on in_valid&in_ready, the block SHALL latch in_a/in_b, set carry reg=in_cin, set slice index=0 and go to BUSY.
REQ-017 BUSY: each cycle, slice idx (bits idx*N+N-1 : idx*N) SHALL be added with the carry reg through one shared N-bit carry-select slice; result written to sum reg slice idx, carry reg <= slice cout, idx++.
REQ-018 BUSY SHALL last exactly K cycles; after slice K-1 the state SHALL go to DONE and out_cout SHALL equal the final slice cout.
REQ-019 DONE: out_valid=1, and out_sum/out_cout SHALL remain stable until out_valid&out_ready, then the state SHALL go to IDLE.
REQ-020 in_ready SHALL be 1 only in IDLE; in_valid in BUSY/DONE SHALL be ignored with no state change.
REQ-021 Latency SHALL be K+1 cycles from the accept edge to out_valid high; min initiation interval K+2 cycles.
REQ-022 Arithmetic SHALL be unsigned modulo 2^W, with {out_cout,out_sum} = in_a+in_b+in_cin.
REQ-023 For K=1, BUSY SHALL last one cycle.
REQ-024 out_sum SHALL not be updated outside BUSY; sum slices not yet computed in BUSY SHALL hold the prior value.

Reset
REQ-025 On rst, regardless of state, the block SHALL go to IDLE and clear out_sum, out_cout, out_valid, busy, the carry reg, idx and the operand regs to 0; in_ready SHALL be 1.
REQ-026 Reset mid-BUSY or mid-DONE SHALL abort the operation with no result presented.

Configuration
REQ-027 With ADDER_OVF_EN defined, the block SHALL add port out_ovf (output, 1), registered with out_sum, equal to the two's-complement overflow (a[W-1]==b[W-1] && sum[W-1]!=a[W-1]), and reset to 0.
REQ-028 With ADDER_OVF_EN undefined, out_ovf and its logic SHALL be absent.

Structure
REQ-029 The FSM state encoding (IDLE=2'd0, BUSY=2'd1, DONE=2'd2) and default N/K SHALL live in the shared adders package.
REQ-030 The slice adder SHALL be one instance of the existing carry_select_adder_block with parameter N; no other sub-module.

Verification
REQ-031 Carry chain: a=32'hFFFF_FFFF, b=32'h1, cin=0 -> out_sum=0, out_cout=1, out_valid 9 cycles after accept.
REQ-032 Carry-in: a=32'h0, b=32'h0, cin=1 -> out_sum=32'h1, out_cout=0.
REQ-033 Backpressure: out_ready low 5 cycles in DONE -> outputs stable, in_ready=0; out_ready=1 -> IDLE next cycle, in_ready=1.
REQ-034 Ignored request: in_valid pulsed during BUSY with a=32'h5 -> first result unaffected, second operand not accepted.
REQ-035 Reset at 4th BUSY cycle -> next cycle IDLE, out_valid=0, out_sum=0; new add 32'h3+32'h4 -> 32'h7.
REQ-036 With ADDER_OVF_EN: 32'h7FFF_FFFF+32'h1 -> out_ovf=1; 32'h8000_0000+32'h8000_0000 -> out_ovf=1, out_cout=1, out_sum=0.
